count_sequencer: RTL and testbench

//  Control FSM for the board-level up/down counter. Turns debounced up/down button levels into

---
 rtl/count_sequencer.sv | 147 ++++++++++++++
 tb/tb_count_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: turns debounced up/down button levels into count steps.
// One step on press, then auto-repeat after HOLD_CYCLES and every
// REPEAT_CYCLES while the button stays held. Saturating or wrapping count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no button active, waiting for a single-button press
//   S_HOLD   | first step taken, timing the initial hold delay
//   S_REPEAT | auto-repeat running, one step per REPEAT_CYCLES
//   S_LOCK   | clear or conflicting buttons seen; wait for both released
module count_sequencer #(
    parameter int WIDTH         = 3,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int WRAP          = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_db,
    input  logic             dn_db,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             at_max,
    output logic             at_min,
    output logic             busy
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(MAXC);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_LOCK   = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [TW-1:0]    HOLD_TC = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    REP_TC  = TW'(REPEAT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             dir_q, dir_d;      // 1: up, 0: down
    logic [WIDTH-1:0] count_q, count_d;
    logic             step_q, step_d;

    logic             do_step;
    logic             step_up;
    logic             held;
    logic             opp;
    logic [TW-1:0]    term;

    // next-state, timer and count arithmetic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        count_d = count_q;
        step_d  = 1'b0;
        do_step = 1'b0;
        step_up = 1'b0;
        held    = dir_q ? up_db : dn_db;
        opp     = dir_q ? dn_db : up_db;
        term    = (state_q == S_HOLD) ? HOLD_TC : REP_TC;

        if (clr) begin
            count_d = '0;
            step_d  = (count_q != '0);
            state_d = S_LOCK;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (up_db ^ dn_db) begin
                        do_step = 1'b1;
                        step_up = up_db;
                        dir_d   = up_db;
                        timer_d = '0;
                        state_d = S_HOLD;
                    end else if (up_db && dn_db) begin
                        state_d = S_LOCK;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (!held) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end else if (opp) begin
                        state_d = S_LOCK;
                        timer_d = '0;
                    end else if (timer_q == term) begin
                        do_step = 1'b1;
                        step_up = dir_q;
                        timer_d = '0;
                        state_d = S_REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    if (!up_db && !dn_db) begin
                        state_d = S_IDLE;
                    end
                end
            endcase

            // at a limit with saturation the step is swallowed, FSM still advances
            if (do_step) begin
                if (step_up) begin
                    if (count_q != CNT_MAX || WRAP != 0) begin
                        count_d = count_q + WIDTH'(1);
                        step_d  = 1'b1;
                    end
                end else begin
                    if (count_q != '0 || WRAP != 0) begin
                        count_d = count_q - WIDTH'(1);
                        step_d  = 1'b1;
                    end
                end
            end
        end
    end

    // state, timer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            step_q  <= step_d;
        end
    end

    assign count  = count_q;
    assign step   = step_q;
    assign at_max = (count_q == CNT_MAX);
    assign at_min = (count_q == '0);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a saturating and a wrapping instance share the
// same stimulus; a reference model pushes expected outputs per edge.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_db = 1'b0;
    logic       dn_db = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] c0, c1;
    logic       s0, s1, mx0, mx1, mn0, mn1, b0, b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(3), .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .up_db(up_db), .dn_db(dn_db), .clr(clr),
        .count(c0), .step(s0), .at_max(mx0), .at_min(mn0), .busy(b0)
    );

    count_sequencer #(.WIDTH(3), .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .up_db(up_db), .dn_db(dn_db), .clr(clr),
        .count(c1), .step(s1), .at_max(mx1), .at_min(mn1), .busy(b1)
    );

    typedef enum int { M_IDLE, M_HOLD, M_REPEAT, M_LOCK } mstate_t;

    typedef struct {
        int inst;
        int cnt;
        int stp;
        int bsy;
    } exp_t;

    exp_t    sb_q[$];
    mstate_t m_st[2];
    int      m_cnt[2];
    int      m_tmr[2];
    int      m_dir[2];
    int      m_stp[2];

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_tmr[i] = 0; m_dir[i] = 0; m_stp[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit u, input bit d, input bit c);
        bit mv = 0;
        bit mup = 0;
        bit hb, ob;
        int tc;
        m_stp[i] = 0;
        if (c) begin
            m_stp[i] = (m_cnt[i] != 0);
            m_cnt[i] = 0;
            m_st[i]  = M_LOCK;
            m_tmr[i] = 0;
        end else begin
            hb = m_dir[i] ? u : d;
            ob = m_dir[i] ? d : u;
            tc = (m_st[i] == M_HOLD) ? 4 : 2;
            case (m_st[i])
                M_IDLE: begin
                    if (u != d) begin
                        mv = 1; mup = u; m_dir[i] = u; m_tmr[i] = 0; m_st[i] = M_HOLD;
                    end else if (u) begin
                        m_st[i] = M_LOCK;
                    end
                end
                M_HOLD, M_REPEAT: begin
                    if (!hb) m_st[i] = M_IDLE;
                    else if (ob) m_st[i] = M_LOCK;
                    else if (m_tmr[i] + 1 == tc) begin
                        mv = 1; mup = m_dir[i]; m_tmr[i] = 0; m_st[i] = M_REPEAT;
                    end else m_tmr[i]++;
                end
                default: if (!u && !d) m_st[i] = M_IDLE;
            endcase
            if (mv) begin
                if (mup) begin
                    if (m_cnt[i] < 7) begin m_cnt[i]++; m_stp[i] = 1; end
                    else if (i == 1) begin m_cnt[i] = 0; m_stp[i] = 1; end
                end else begin
                    if (m_cnt[i] > 0) begin m_cnt[i]--; m_stp[i] = 1; end
                    else if (i == 1) begin m_cnt[i] = 7; m_stp[i] = 1; end
                end
            end
        end
    endtask

    // one clock edge with the inputs currently applied
    task automatic do_cycle();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            model_edge(i, up_db, dn_db, clr);
            e.inst = i; e.cnt = m_cnt[i]; e.stp = m_stp[i];
            e.bsy = (m_st[i] != M_IDLE) ? 1 : 0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                if (e.inst == 0) begin
                    check_eq("sat_count", int'(c0), e.cnt);
                    check_eq("sat_step", int'(s0), e.stp);
                    check_eq("sat_busy", int'(b0), e.bsy);
                    check_eq("sat_at_max", int'(mx0), (e.cnt == 7) ? 1 : 0);
                    check_eq("sat_at_min", int'(mn0), (e.cnt == 0) ? 1 : 0);
                end else begin
                    check_eq("wrap_count", int'(c1), e.cnt);
                    check_eq("wrap_step", int'(s1), e.stp);
                    check_eq("wrap_busy", int'(b1), e.bsy);
                    check_eq("wrap_at_max", int'(mx1), (e.cnt == 7) ? 1 : 0);
                    check_eq("wrap_at_min", int'(mn1), (e.cnt == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic drive(input bit u, input bit d, input bit c, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            up_db = u; dn_db = d; clr = c;
            do_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int steps;
        model_reset();
        #3;
        check_eq("rst_count", int'(c0), 0);
        check_eq("rst_step", int'(s0), 0);
        check_eq("rst_busy", int'(b0), 0);
        check_eq("rst_at_min", int'(mn0), 1);
        #1 rst_n = 1'b1;

        // single tap from 0
        drive(1, 0, 0, 1);
        check_eq("tap_count", int'(c0), 1);
        check_eq("tap_step", int'(s0), 1);
        drive(0, 0, 0, 1);
        check_eq("tap_step_drop", int'(s0), 0);
        check_eq("tap_idle", int'(b0), 0);

        // held 10 edges: steps at k, k+4, k+6, k+8
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        steps = 0;
        for (int j = 0; j < 10; j++) begin
            drive(1, 0, 0, 1);
            if (s0) steps++;
            check_eq("hold_step_pos", int'(s0), (j == 0 || j == 4 || j == 6 || j == 8) ? 1 : 0);
        end
        check_eq("hold_steps", steps, 4);
        check_eq("hold_count", int'(c0), 4);
        drive(0, 0, 0, 1);
        check_eq("hold_release_idle", int'(b0), 0);

        // saturation and wrap at max
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 15);
        check_eq("ramp_sat", int'(c0), 7);
        check_eq("ramp_wrap", int'(c1), 7);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        check_eq("sat_tap_count", int'(c0), 7);
        check_eq("sat_tap_step", int'(s0), 0);
        check_eq("sat_tap_at_max", int'(mx0), 1);
        check_eq("wrap_tap_count", int'(c1), 0);
        check_eq("wrap_tap_step", int'(s1), 1);
        drive(0, 0, 0, 1);
        steps = 0;
        for (int j = 0; j < 8; j++) begin
            drive(1, 0, 0, 1);
            if (s0) steps++;
        end
        check_eq("sat_hold_steps", steps, 0);
        check_eq("sat_hold_count", int'(c0), 7);
        check_eq("sat_hold_at_max", int'(mx0), 1);

        // conflicting buttons lock out
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 5);
        check_eq("pre_conf_count", int'(c0), 2);
        drive(0, 0, 0, 1);
        drive(1, 1, 0, 2);
        check_eq("conf_count", int'(c0), 2);
        check_eq("conf_lock", int'(b0), 1);
        drive(0, 1, 0, 1);
        check_eq("conf_still_lock", int'(b0), 1);
        check_eq("conf_no_step", int'(s0), 0);
        drive(0, 0, 0, 1);
        check_eq("conf_idle", int'(b0), 0);
        drive(0, 1, 0, 1);
        check_eq("dn_tap_count", int'(c0), 1);
        check_eq("dn_tap_step", int'(s0), 1);
        drive(0, 0, 0, 1);

        // clear mid-repeat with up held
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 11);
        check_eq("pre_clr_count", int'(c0), 5);
        drive(1, 0, 1, 1);
        check_eq("clr_count", int'(c0), 0);
        check_eq("clr_step", int'(s0), 1);
        check_eq("clr_lock", int'(b0), 1);
        steps = 0;
        for (int j = 0; j < 5; j++) begin
            drive(1, 0, 0, 1);
            if (s0) steps++;
        end
        check_eq("clr_lock_steps", steps, 0);
        check_eq("clr_lock_count", int'(c0), 0);
        drive(0, 0, 0, 1);
        check_eq("clr_release_idle", int'(b0), 0);

        // async reset mid-repeat, release with up held
        drive(1, 0, 0, 13);
        check_eq("pre_rst_count", int'(c0), 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", int'(c0), 0);
        check_eq("arst_step", int'(s0), 0);
        check_eq("arst_busy", int'(b0), 0);
        model_reset();
        #1 rst_n = 1'b1;
        do_cycle();
        check_eq("post_rst_count", int'(c0), 1);
        check_eq("post_rst_step", int'(s0), 1);
        drive(0, 0, 0, 2);
        check_eq("final_idle", int'(b0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
